// File: rtl/dynamic_buff_pkg.sv
// Shared types for the dynamic_buff FIFO. Holds only the push/pop accept
// encoding; every width is derived locally from each module's parameters.
package dynamic_buff_pkg;

  // {push_acc, pop_acc} packed into one code so the occupancy update reads as a case.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } acc_op_e;

endpackage : dynamic_buff_pkg

// File: rtl/dynamic_buff_ptr.sv
// Wrapping pointer for dynamic_buff. It counts 0..NUMELEM-1 and wraps on an
// explicit compare, so non-power-of-two depths work.
module buff_ptr #(
  parameter int NUMELEM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       clr,
  output logic [$clog2(NUMELEM)-1:0] ptr
);

  localparam int BITELEM = $clog2(NUMELEM);
  localparam logic [BITELEM-1:0] LAST = BITELEM'(NUMELEM - 1);

  logic [BITELEM-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)            ptr_d = '0;
    else if (inc)       ptr_d = (ptr_q == LAST) ? '0 : ptr_q + BITELEM'(1);
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule : buff_ptr

// File: rtl/dynamic_buff.sv
// First-word-fall-through FIFO of arbitrary depth with occupancy count,
// full/empty/almost flags and a synchronous flush.
module dynamic_buff
  import dynamic_buff_pkg::*;
#(
  parameter int NUMELEM   = 4,
  parameter int BITDATA   = 4,
  parameter int AFULL_TH  = NUMELEM - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  output logic                         push_rdy,
  input  logic [BITDATA-1:0]           pu_din,
  output logic                         pop_vld,
  input  logic                         pop_rdy,
  output logic [BITDATA-1:0]           po_dout,
  input  logic                         flush,
  output logic [$clog2(NUMELEM):0]     count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int BITELEM = $clog2(NUMELEM);
  localparam logic [BITELEM:0] CNT_MAX = (BITELEM + 1)'(NUMELEM);
  localparam logic [BITELEM:0] CNT_AF  = (BITELEM + 1)'(AFULL_TH);
  localparam logic [BITELEM:0] CNT_AE  = (BITELEM + 1)'(AEMPTY_TH);
  localparam logic [BITELEM:0] CNT_ONE = (BITELEM + 1)'(1);

  logic [BITDATA-1:0] mem_q [NUMELEM];
  logic [BITELEM:0]   count_q, count_d;
  logic [BITELEM-1:0] head, tail;
  logic               push_acc, pop_acc, wr_en;
  acc_op_e            op;

  assign push_acc = push_vld && push_rdy;
  assign pop_acc  = pop_vld && pop_rdy;
  assign wr_en    = push_acc && rst && !flush;
  assign op       = acc_op_e'({push_acc, pop_acc});

  buff_ptr #(.NUMELEM(NUMELEM)) u_head (
    .clk (clk), .rst (rst), .inc (pop_acc),  .clr (flush), .ptr (head)
  );

  buff_ptr #(.NUMELEM(NUMELEM)) u_tail (
    .clk (clk), .rst (rst), .inc (push_acc), .clr (flush), .ptr (tail)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case (op)
        OP_PUSH: count_d = count_q + CNT_ONE;
        OP_POP:  count_d = count_q - CNT_ONE;
        OP_BOTH, OP_IDLE: count_d = count_q;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail] <= pu_din;
  end

  assign po_dout      = mem_q[head];
  assign count        = count_q;
  assign full         = (count_q == CNT_MAX);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign push_rdy     = !full;
  assign pop_vld      = !empty;

`ifdef FORMAL
  // Shift-register reference: entry 0 is always the oldest element.
  logic [BITDATA-1:0] ref_q [NUMELEM];
  logic [BITELEM:0]   ref_cnt;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + (push_acc ? CNT_ONE : '0) - (pop_acc ? CNT_ONE : '0);
      for (int i = 0; i < NUMELEM - 1; i++) begin
        if (pop_acc) ref_q[i] <= ref_q[i+1];
      end
      if (push_acc) ref_q[ref_cnt - (pop_acc ? CNT_ONE : '0)] <= pu_din;
    end
  end

  a_no_push_full:  assert property (@(posedge clk) disable iff (!rst) !(push_acc && full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst) !(pop_acc && empty));
  a_count_match:   assert property (@(posedge clk) disable iff (!rst) count_q == ref_cnt);
  a_pop_data:      assert property (@(posedge clk) disable iff (!rst) pop_acc |-> po_dout == ref_q[0]);
`endif

endmodule : dynamic_buff

// File: doc/dynamic_buff.md
DYNAMIC_BUFF -- requirements
Module: dynamic_buff

Interface
REQ-001 The block SHALL take parameter NUMELEM, default 4, as the FIFO depth in entries; any integer >= 2 is allowed, including non-powers of two.
REQ-002 The block SHALL take parameter BITDATA, default 4, as the entry width in bits.
REQ-003 The block SHALL take parameter AFULL_TH, default NUMELEM-1, as the almost_full threshold in entries.
REQ-004 The block SHALL take parameter AEMPTY_TH, default 1, as the almost_empty threshold in entries.
REQ-005 The block SHALL define BITELEM = clog2(NUMELEM) as a derived localparam, not overridable.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 push_vld  in  1  write request.
REQ-009 push_rdy  out  1  write accept; equals !full.
REQ-010 pu_din  in  BITDATA  write data.
REQ-011 pop_vld  out  1  head entry valid; equals !empty.
REQ-012 pop_rdy  in  1  read request.
REQ-013 po_dout  out  BITDATA  head entry data, first-word-fall-through.
REQ-014 flush  in  1  synchronous clear of contents.
REQ-015 count  out  BITELEM+1  current occupancy.
REQ-016 full, empty, almost_full, almost_empty  out  1 each  status flags.

Function
REQ-017 A push SHALL be accepted in a cycle when push_vld && push_rdy; a pop SHALL be accepted when pop_vld && pop_rdy.
REQ-018 Requests not accepted SHALL have no effect and SHALL NOT be treated as errors.
REQ-019 head and tail SHALL be independent BITELEM-bit pointers that increment by 1 per accepted pop or push respectively, wrapping from NUMELEM-1 to 0 by explicit compare, not by modulo.
REQ-020 count SHALL update to count + push_acc - pop_acc; it SHALL never exceed NUMELEM and never underflow.
REQ-021 An accepted push SHALL write pu_din to mem[tail] on the same edge.
REQ-022 po_dout SHALL equal mem[head] combinationally.
REQ-023 Write-to-read latency SHALL be 1 cycle: data pushed into an empty buffer shows pop_vld=1 on the next cycle.
REQ-024 Simultaneous push and pop accepted while full is impossible, because push_rdy=0 when full.
REQ-025 Simultaneous push and pop accepted at 0 < count < NUMELEM SHALL leave count unchanged and advance both pointers.
REQ-026 po_dout SHALL be don't-care while empty; the bench SHALL NOT check it then.
REQ-027 full SHALL be (count==NUMELEM), empty (count==0), almost_full (count>=AFULL_TH), and almost_empty (count<=AEMPTY_TH), all derived from registered count.
REQ-028 flush=1 SHALL set count, head, and tail to 0 on the next edge, overriding any push or pop that cycle; memory contents need not be cleared.

Reset
REQ-029 While rst=0 at a clock edge, count, head, and tail SHALL become 0; after reset, empty=1, pop_vld=0, push_rdy=1, full=0, almost_empty=1, and almost_full=0 (for AFULL_TH>0).
REQ-030 Reset mid-operation SHALL discard all contents and ignore push and pop in that cycle; memory SHALL NOT be reset.

Structure
REQ-031 A sub-module buff_ptr (wrapping counter, parameter NUMELEM, inputs inc and clr) SHALL be instantiated twice, once for head and once for tail.
REQ-032 No shared package is required; all widths SHALL be derived locally from parameters.
REQ-033 Storage SHALL be a register array of NUMELEM x BITDATA.
REQ-034 Formal checks SHALL compare against a shift-register reference model under FORMAL, with assertions: no accept when full or empty, and popped data equals reference head.

Verification (NUMELEM=5, BITDATA=8, AFULL_TH=4, AEMPTY_TH=1)
REQ-035 Reset, then push 0x11..0x55 -> count=5, full=1, push_rdy=0; a 6th push_vld is ignored; pops return 0x11..0x55 in order, then empty=1.
REQ-036 Non-power-of-two wrap: 3 push/pop rounds of 4 entries each -> pointers wrap 4->0; data order is preserved and no entry is skipped.
REQ-037 At count=3, push 0xAA with pop in the same cycle -> count stays 3, po_dout advances, 0xAA is returned in order.
REQ-038 Push 0x7E into empty -> pop_vld=0 that cycle, pop_vld=1 and po_dout=0x7E the next cycle.
REQ-039 At count=4, assert flush together with push and pop -> next cycle count=0, empty=1; a following push of 0x33 pops back as 0x33.
REQ-040 Flags: count 0->5 -> almost_empty=1 at count 0-1, almost_full=1 at count 4-5; apply rst=0 at count=3 -> count=0 next cycle.
